sprite_row_fetcher: RTL and testbench

//   Reader/initiator for the sprite-sheet ROMs (kirby, waddle): given a frame index and a line within the

---
 rtl/sprite_row_fetcher.sv | 147 ++++++++++++++
 tb/tb_sprite_row_fetcher.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_row_fetcher.sv
// Purpose : fetches one SPR_W-pixel line of a sprite frame from the sheet ROM into a
//           double-buffered line buffer (optional horizontal flip) for the compositor.
// Latency : start sampled at E0 -> done pulse in the cycle after E(SPR_W+1); rd_pixel 1 cycle after rd_x.
// Backpr. : none; start is only taken in IDLE (ignored while busy), bad frame -> err pulse.
// Ports   : Clk/Reset_n (async active-low); start/frame_idx/row/flip request a line;
//           busy/done/err status; R_ADDR/data_In ROM read port (1-cycle registered ROM);
//           rd_x -> rd_pixel/rd_opaque compositor read of the front bank.
module sprite_row_fetcher #(
  parameter int          SHEET_W    = 256,
  parameter int          SPR_W      = 32,
  parameter int          SPR_H      = 32,
  parameter int          NUM_FRAMES = 48,
  parameter int          ADDR_W     = 20,
  parameter logic [7:0]  TRANSP     = 8'h00
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       start,
  input  logic [5:0]                 frame_idx,
  input  logic [$clog2(SPR_H)-1:0]   row,
  input  logic                       flip,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDR_W-1:0]          R_ADDR,
  input  logic [7:0]                 data_In,
  input  logic [$clog2(SPR_W)-1:0]   rd_x,
  output logic [7:0]                 rd_pixel,
  output logic                       rd_opaque
);

  localparam int X_W      = $clog2(SPR_W);
  localparam int SPRH_LG  = $clog2(SPR_H);
  localparam int SHEET_LG = $clog2(SHEET_W);
  localparam int FPR      = SHEET_W / SPR_W;   // frames per sheet row
  localparam int FPR_LG   = $clog2(FPR);

  localparam logic [6:0]   NF        = 7'(NUM_FRAMES);
  localparam logic [X_W:0] LAST_STEP = (X_W+1)'(SPR_W - 2);
  localparam logic [X_W:0] SWAP_CNT  = (X_W+1)'(SPR_W);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_nxt;

  // cnt counts edges since the accepting edge: an edge seen with cnt=c is E(c+1).
  logic [X_W:0]       cnt;
  logic [ADDR_W-1:0]  base_q;
  logic               flip_q;
  logic               front;
  logic [7:0]         buf_mem [2*SPR_W];

  logic               acc, rej, step, wr_en, swap;
  logic [ADDR_W-1:0]  fx_a, fy_a, base_in;
  logic [X_W-1:0]     wk, wr_idx;

  // Power-of-two geometry: every product is a shift and every sum of disjoint
  // bit fields is an OR.
  assign fx_a    = ADDR_W'(frame_idx) & ADDR_W'(FPR - 1);
  assign fy_a    = ADDR_W'(frame_idx) >> FPR_LG;
  assign base_in = (((fy_a << SPRH_LG) | ADDR_W'(row)) << SHEET_LG) | (fx_a << X_W);

  // Data returning at E(k+2) belongs to column k = cnt-1 (wraps to SPR_W-1 at the swap edge).
  assign wk     = cnt[X_W-1:0] - X_W'(1);
  assign wr_idx = flip_q ? ~wk : wk;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc       = 1'b0;
    rej       = 1'b0;
    step      = 1'b0;
    wr_en     = 1'b0;
    swap      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ({1'b0, frame_idx} < NF) begin
            acc       = 1'b1;
            state_nxt = FETCH;
          end else begin
            rej = 1'b1;
          end
        end
      end
      FETCH: begin
        step  = 1'b1;
        wr_en = (cnt != '0);
        if (cnt == LAST_STEP) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Two more ROM words are still in flight after the last address.
        wr_en = 1'b1;
        if (cnt == SWAP_CNT) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= '0;
      base_q    <= '0;
      flip_q    <= 1'b0;
      R_ADDR    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      front     <= 1'b0;
      rd_pixel  <= 8'h00;
      rd_opaque <= 1'b0;
    end else begin
      done <= swap;
      err  <= rej;
      if (acc) begin
        base_q <= base_in;
        flip_q <= flip;
        R_ADDR <= base_in;
        busy   <= 1'b1;
        cnt    <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (step) R_ADDR <= base_q + ADDR_W'(cnt) + ADDR_W'(1);
      if (swap) begin
        front <= ~front;
        busy  <= 1'b0;
      end
      // Read uses the pre-swap front value on the swap edge.
      rd_pixel  <= buf_mem[{front, rd_x}];
      rd_opaque <= (buf_mem[{front, rd_x}] != TRANSP);
    end
  end

  // Only the back bank is ever written, so the compositor never sees a partial line.
  always_ff @(posedge Clk) begin
    if (wr_en) buf_mem[{~front, wr_idx}] <= data_In;
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
module tb_sprite_row_fetcher;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [5:0]  frame_idx;
  logic [4:0]  row;
  logic        flip;
  logic        busy;
  logic        done;
  logic        err;
  logic [19:0] R_ADDR;
  logic [7:0]  data_In;
  logic [4:0]  rd_x;
  logic [7:0]  rd_pixel;
  logic        rd_opaque;

  int total = 0;
  int bad   = 0;

  sprite_row_fetcher dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_idx(frame_idx), .row(row),
    .flip(flip), .busy(busy), .done(done), .err(err), .R_ADDR(R_ADDR),
    .data_In(data_In), .rd_x(rd_x), .rd_pixel(rd_pixel), .rd_opaque(rd_opaque)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered ROM model: mem[a] = a[7:0].
  always @(posedge Clk) data_In <= R_ADDR[7:0];

  // Waits (bounded) for a done pulse; the caller decides whether a timeout is a failure.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge Clk);
    total++;
    if (busy !== 0 || done !== 0 || err !== 0 || R_ADDR !== 20'd0 || rd_pixel !== 8'h00 || rd_opaque !== 0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b err=%b addr=%0d pix=%h opq=%b want all zero",
               busy, done, err, R_ADDR, rd_pixel, rd_opaque);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic;
    frame_idx = 6'd0; row = 5'd0; flip = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      total++;
      if (R_ADDR !== 20'(k) || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_addr E%0d got addr=%0d busy=%b done=%b want addr=%0d busy=1 done=0",
                 k, R_ADDR, busy, done, k);
      end
      @(negedge Clk);
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || R_ADDR !== 20'd31) begin
      bad++;
      $display("FAIL basic_e32 got done=%b busy=%b addr=%0d want done=0 busy=1 addr=31", done, busy, R_ADDR);
    end
    @(negedge Clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_latency got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    @(negedge Clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse got done=%b want 0", done);
    end
    for (int k = 0; k < 32; k++) begin
      rd_x = 5'(k);
      @(negedge Clk);
      total++;
      if (rd_pixel !== 8'(k) || rd_opaque !== (k != 0)) begin
        bad++;
        $display("FAIL basic_read x=%0d got pix=%h opq=%b want pix=%h opq=%b",
                 k, rd_pixel, rd_opaque, 8'(k), (k != 0));
      end
    end
  endtask

  task automatic test_addr_frame9;
    logic [19:0] exp_a;
    bit seen;
    frame_idx = 6'd9; row = 5'd5; flip = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp_a = 20'd9504 + 20'(k);
      total++;
      if (R_ADDR !== exp_a) begin
        bad++;
        $display("FAIL f9_addr E%0d got %0d want %0d", k, R_ADDR, exp_a);
      end
      @(negedge Clk);
    end
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL f9_done got no done want done pulse");
    end
    rd_x = 5'd3;
    @(negedge Clk);
    total++;
    if (rd_pixel !== 8'h23 || rd_opaque !== 1'b1) begin
      bad++;
      $display("FAIL f9_read3 got pix=%h opq=%b want 23 1", rd_pixel, rd_opaque);
    end
    rd_x = 5'd0;
    @(negedge Clk);
    total++;
    if (rd_pixel !== 8'h20) begin
      bad++;
      $display("FAIL f9_read0 got pix=%h want 20", rd_pixel);
    end
  endtask

  task automatic test_flip;
    bit seen;
    frame_idx = 6'd0; row = 5'd0; flip = 1'b1; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL flip_done got no done want done pulse");
    end
    rd_x = 5'd0;
    @(negedge Clk);
    total++;
    if (rd_pixel !== 8'd31 || rd_opaque !== 1'b1) begin
      bad++;
      $display("FAIL flip_x0 got pix=%0d opq=%b want 31 1", rd_pixel, rd_opaque);
    end
    rd_x = 5'd31;
    @(negedge Clk);
    total++;
    if (rd_pixel !== 8'd0 || rd_opaque !== 1'b0) begin
      bad++;
      $display("FAIL flip_x31 got pix=%0d opq=%b want 0 0", rd_pixel, rd_opaque);
    end
    rd_x = 5'd3;
    @(negedge Clk);
    total++;
    if (rd_pixel !== 8'd28) begin
      bad++;
      $display("FAIL flip_x3 got pix=%0d want 28", rd_pixel);
    end
    flip = 1'b0;
  endtask

  // start held for 80 edges E0..E79: done pulses after E33 and E67 only; a third
  // fetch is accepted at E68 and finishes after the window.
  task automatic test_back_to_back;
    bit          seen;
    logic        exp_done;
    logic [7:0]  exp_pix;
    rd_x = 5'd3;
    frame_idx = 6'd9; row = 5'd5; flip = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge Clk);
      exp_done = (cyc == 33 || cyc == 67);
      exp_pix  = (cyc <= 33) ? 8'd28 : (cyc <= 67) ? 8'h23 : 8'h03;
      total++;
      if (done !== exp_done || busy !== !exp_done || err !== 1'b0 || rd_pixel !== exp_pix) begin
        bad++;
        $display("FAIL b2b cyc=%0d got done=%b busy=%b err=%b pix=%h want done=%b busy=%b err=0 pix=%h",
                 cyc, done, busy, err, rd_pixel, exp_done, !exp_done, exp_pix);
      end
      if (cyc == 33) begin
        frame_idx = 6'd0;
        row       = 5'd0;
      end
    end
    start = 1'b0;
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_third_done got no done want done pulse");
    end
    @(negedge Clk);
  endtask

  task automatic test_err;
    bit seen;
    rd_x = 5'd3;
    frame_idx = 6'd48; row = 5'd0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || R_ADDR !== 20'd31 || done !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse got err=%b busy=%b addr=%0d done=%b want 1 0 31 0", err, busy, R_ADDR, done);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      total++;
      if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || R_ADDR !== 20'd31) begin
        bad++;
        $display("FAIL err_quiet cyc=%0d got err=%b done=%b busy=%b addr=%0d want 0 0 0 31",
                 i, err, done, busy, R_ADDR);
      end
    end
    total++;
    if (rd_pixel !== 8'h03) begin
      bad++;
      $display("FAIL err_front got pix=%h want 03", rd_pixel);
    end
    // Highest valid frame at the last row: (5*32+31)*256 + 7*32 = 49120.
    frame_idx = 6'd47; row = 5'd31; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (err !== 1'b0 || busy !== 1'b1 || R_ADDR !== 20'd49120) begin
      bad++;
      $display("FAIL err_f47 got err=%b busy=%b addr=%0d want 0 1 49120", err, busy, R_ADDR);
    end
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL f47_done got no done want done pulse");
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    frame_idx = 6'd0; row = 5'd1; flip = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (11) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || R_ADDR !== 20'd0) begin
      bad++;
      $display("FAIL rst_mid got busy=%b done=%b addr=%0d want 0 0 0", busy, done, R_ADDR);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_abort cyc=%0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    frame_idx = 6'd2; row = 5'd0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (R_ADDR !== 20'd64 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_refetch got addr=%0d busy=%b want 64 1", R_ADDR, busy);
    end
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rst_refetch_done got no done want done pulse");
    end
    rd_x = 5'd5;
    @(negedge Clk);
    total++;
    if (rd_pixel !== 8'h45) begin
      bad++;
      $display("FAIL rst_refetch_read got pix=%h want 45", rd_pixel);
    end
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; frame_idx = '0; row = '0; flip = 1'b0; rd_x = '0;
    test_reset();
    test_basic();
    test_addr_frame9();
    test_flip();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
